sar8_ctrl: RTL and testbench

- 8-bit successive-approximation register (SAR) control logic, packaged as the Tiny Tapeout top-level wrapper.
- Samples an external comparator bit once per clock and resolves one result bit per cycle, MSB first.
- Drives the trial/result code to the external DAC and raises a done flag after 8 decisions.
- Sits between the off-chip comparator and the off-chip R-2R DAC.

---
 rtl/sar8_ctrl_if.sv | 19 +
 rtl/sar8_ctrl.sv | 60 ++++++
 tb/tb_sar8_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/sar8_ctrl_if.sv
// rtl/sar8_ctrl_if.sv - Tiny Tapeout pin bundle for the SAR controller
interface sar8_ctrl_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/sar8_ctrl.sv
// rtl/sar8_ctrl.sv - 8-bit successive-approximation controller, one decision per enabled clock
// The trial code goes straight from the SAR register to the DAC pins; done latches until reset.
module sar8_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  sar8_ctrl_if.slave  bus
);

  localparam int PW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_sar;
  logic [PW-1:0]    r_ptr;
  logic             r_done;

  logic [WIDTH-1:0] w_sar_nxt;
  logic [PW-1:0]    w_ptr_nxt;
  logic             w_done_nxt;
  logic             w_cmp;
  logic             w_unused;

  assign w_cmp    = bus.ui_in[0];
  assign w_unused = ^{bus.ui_in[7:1], bus.uio_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sar  <= WIDTH'(1) << (WIDTH - 1);
      r_ptr  <= PW'(WIDTH - 1);
      r_done <= 1'b0;
    end else begin
      r_sar  <= w_sar_nxt;
      r_ptr  <= w_ptr_nxt;
      r_done <= w_done_nxt;
    end
  end

  // Resolve the bit under test and arm the next lower one as the new trial bit.
  always_comb begin
    w_sar_nxt  = r_sar;
    w_ptr_nxt  = r_ptr;
    w_done_nxt = r_done;
    if (bus.ena && !r_done) begin
      w_sar_nxt[r_ptr] = w_cmp;
      if (r_ptr != '0) begin
        w_sar_nxt[r_ptr - 1'b1] = 1'b1;
        w_ptr_nxt               = r_ptr - 1'b1;
      end else begin
        w_done_nxt = 1'b1;
      end
    end
  end

  always_comb begin
    bus.uo_out  = 8'(r_sar);
    bus.uio_out = {6'b0, ~r_done, r_done};
    bus.uio_oe  = 8'b0000_0011;
  end

endmodule

// File: tb/tb_sar8_ctrl.sv
// tb/tb_sar8_ctrl.sv - table-driven and scoreboarded checks of sar8_ctrl
module tb_sar8_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;

  sar8_ctrl_if bus ();

  sar8_ctrl #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] comp;
    logic [7:0] exp_final;
  } vec_t;

  typedef struct {
    logic [7:0] uo;
    logic [7:0] uio;
  } exp_t;

  vec_t       vecs[4];
  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] m_dec;
  int         m_n;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected SAR contents after n decisions: decided bits on top, trial bit just below.
  function automatic logic [7:0] exp_code(input logic [7:0] dec, input int n);
    logic [7:0] mask;
    logic [7:0] trial;
    mask  = 8'hFF << (8 - n);
    trial = (n < 8) ? (8'h80 >> n) : 8'h00;
    return (dec & mask) | trial;
  endfunction

  task automatic apply_reset();
    #1;
    rst = 1'b1;
    #1;
    check("rst_uo_out",  bus.uo_out,  8'h80);
    check("rst_uio_out", bus.uio_out, 8'h02);
    check("rst_uio_oe",  bus.uio_oe,  8'h03);
    m_dec = 8'h00;
    m_n   = 0;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input logic c, input logic en);
    exp_t e;
    bus.ena    = en;
    bus.ui_in  = {7'($urandom), c};
    bus.uio_in = 8'($urandom);
    if (en && m_n < 8) begin
      m_dec[7 - m_n] = c;
      m_n++;
    end
    e.uo  = exp_code(m_dec, m_n);
    e.uio = {6'b0, m_n < 8, m_n == 8};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("step_uo_out",  bus.uo_out,  e.uo);
    check("step_uio_out", bus.uio_out, e.uio);
  endtask

  initial begin
    logic [7:0] bits;
    logic [7:0] held;

    vecs[0] = '{comp: 8'hFF, exp_final: 8'hFF};
    vecs[1] = '{comp: 8'h00, exp_final: 8'h00};
    vecs[2] = '{comp: 8'hAA, exp_final: 8'hAA};
    vecs[3] = '{comp: 8'h65, exp_final: 8'h65};

    bus.ena    = 1'b1;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;
    #2;

    for (int i = 0; i < 4; i++) begin
      apply_reset();
      for (int k = 0; k < 8; k++) step(vecs[i].comp[7 - k], 1'b1);
      check("vec_final", bus.uo_out, vecs[i].exp_final);
      check("vec_done",  {7'b0, bus.uio_out[0]}, 8'h01);
    end

    for (int r = 0; r < 120; r++) begin
      apply_reset();
      bits = 8'($urandom);
      for (int k = 0; k < 8; k++) step(bits[7 - k], 1'b1);
      check("rand_final", bus.uo_out, bits);
    end

    // Reset after four decisions must clear asynchronously (checked inside apply_reset).
    apply_reset();
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1);
    check("pre_rst_uo", bus.uo_out, 8'hF8);
    apply_reset();
    for (int k = 0; k < 8; k++) step(vecs[3].comp[7 - k], 1'b1);
    check("post_rst_final", bus.uo_out, 8'h65);

    // Pause with ena low for three cycles mid-conversion.
    apply_reset();
    bits = 8'hB5;
    for (int k = 0; k < 3; k++) step(bits[7 - k], 1'b1);
    held = bus.uo_out;
    check("pause_entry", held, 8'hB0);
    for (int k = 0; k < 3; k++) begin
      step(~bits[4], 1'b0);
      check("pause_hold", bus.uo_out, held);
    end
    for (int k = 3; k < 8; k++) step(bits[7 - k], 1'b1);
    check("pause_final", bus.uo_out, 8'hB5);
    check("pause_done",  bus.uio_out, 8'h01);

    // After done the comparator is ignored.
    held = bus.uo_out;
    for (int k = 0; k < 6; k++) begin
      step(k[0], 1'b1);
      check("done_hold", bus.uo_out, held);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
